// File: rtl/mem_arb_pkg.sv
// Shared FSM/owner encodings and latency limits for mem_port_arbiter.
// The MEM_ARB_RR_EN macro is consumed by arb_pick, not by this package.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = 3;

    function automatic bit lat_in_range(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise D has fixed priority over IF.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   pick_valid,
    output owner_t pick
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Winner selection; D is the fallback so pick is never undriven.
    always_comb begin
        pick_valid = if_req | d_req;
        pick       = OWN_D;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            pick = (last_owner == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req) begin
            pick = OWN_IF;
        end else begin
            pick = OWN_D;
        end
`else
        if (d_req) begin
            pick = OWN_D;
        end else if (if_req) begin
            pick = OWN_IF;
        end else begin
            pick = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store paths.
// Define MEM_ARB_RR_EN for round-robin arbitration (fixed D-over-IF otherwise).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    if (!lat_in_range(LAT)) begin : g_lat_check
        $error("mem_port_arbiter: LAT out of range");
    end

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LAT >= 2) ? (LAT - 2) : 0);

    arb_state_t        state_r, state_n;
    owner_t            owner_r, owner_n, last_owner_r, pick;
    logic              we_r, we_n, load_s, pick_valid, resp_load_s;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [DW-1:0]     if_rdata_r, d_rdata_r;

    arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (last_owner_r),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // Next-state logic; the request is latched only on the IDLE->ISSUE step.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        we_n    = we_r;
        cnt_n   = cnt_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_n = {CNT_W{1'b0}};
                if (pick_valid) begin
                    state_n = ISSUE;
                    load_s  = 1'b1;
                    owner_n = pick;
                    we_n    = (pick == OWN_D) && d_we;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (we_r || (LAT == 1)) begin
                    state_n = RESP;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_n = RESP;
                end else begin
                    state_n = WAIT;
                    cnt_n   = cnt_r + CNT_W'(1);
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register with the latched owner, direction and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= OWN_IF;
            we_r         <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            last_owner_r <= OWN_IF;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            we_r    <= we_n;
            cnt_r   <= cnt_n;
            if (load_s) begin
                last_owner_r <= owner_n;
            end
        end
    end

    assign resp_load_s = (state_r == RESP) && !we_r;

    // Registered handshake and memory-side outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            mem_wdata  <= {DW{1'b0}};
            busy       <= 1'b0;
            if_rdata_r <= {DW{1'b0}};
            d_rdata_r  <= {DW{1'b0}};
        end else begin
            if_gnt    <= load_s && (owner_n == OWN_IF);
            d_gnt     <= load_s && (owner_n == OWN_D);
            mem_en    <= load_s;
            mem_we    <= load_s && we_n;
            if_rvalid <= (state_n == RESP) && (owner_n == OWN_IF);
            d_rvalid  <= (state_n == RESP) && (owner_n == OWN_D);
            busy      <= (state_n != IDLE);
            if (load_s) begin
                mem_addr <= (owner_n == OWN_D) ? d_addr : if_addr;
                if (owner_n == OWN_D) begin
                    mem_wdata <= d_wdata;
                end
            end
            if (resp_load_s) begin
                if (owner_r == OWN_IF) begin
                    if_rdata_r <= mem_rdata;
                end else begin
                    d_rdata_r <= mem_rdata;
                end
            end
        end
    end

    // Read data is forwarded in the RESP cycle so it lines up with rvalid.
    assign if_rdata = (resp_load_s && (owner_r == OWN_IF)) ? mem_rdata : if_rdata_r;
    assign d_rdata  = (resp_load_s && (owner_r == OWN_D))  ? mem_rdata : d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random and directed traffic against a
// transaction-level model of grants, memory contents and response timing.
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic logic [15:0] init_word(input int i);
        if (i == 4) return 16'hA5A5;
        return 16'(i * 40503 + 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for grant (cycle %0d)", name, cyc);
    endtask

    // Behavioural RAM with LAT-cycle read pipeline
    logic [15:0] ram [64];
    logic [15:0] rpipe [LAT];
    bit          ram_init = 1'b0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[5:0]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        rpipe[0] <= ram[mem_addr[5:0]];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    // Scoreboard: expected responses queued at grant, consumed at rvalid
    typedef struct {
        bit          own_d;
        bit          st;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] shadow [64];

    initial begin : monitor
        exp_t        e;
        bit          gi, gd, dw, st, busy_exp, rv_i, rv_d, last_d;
        bit          prev_reset, prev_idle, p_if_req, p_d_req, p_d_we;
        logic [15:0] a, p_if_addr, p_d_addr, p_d_wdata, exp_if_rdata, exp_d_rdata;
        prev_reset = 1'b1;
        prev_idle  = 1'b1;
        last_d     = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_reset) begin
                chk("reset_ctrl", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}), 32'd0);
                chk("reset_data", 32'(|{if_rdata, d_rdata, mem_addr, mem_wdata}), 32'd0);
                q.delete();
                exp_if_rdata = '0;
                exp_d_rdata  = '0;
                last_d       = 1'b0;
                prev_idle    = 1'b1;
            end else begin
`ifdef MEM_ARB_RR_EN
                dw = !last_d;
`else
                dw = 1'b1;
`endif
                gd = prev_idle && p_d_req && (!p_if_req || dw);
                gi = prev_idle && p_if_req && !gd;
                chk("if_gnt", 32'(if_gnt), 32'(gi));
                chk("d_gnt", 32'(d_gnt), 32'(gd));
                chk("mem_en", 32'(mem_en), 32'(gi | gd));
                if (gi || gd) begin
                    st = gd && p_d_we;
                    a  = gd ? p_d_addr : p_if_addr;
                    chk("mem_addr", 32'(mem_addr), 32'(a));
                    chk("mem_we", 32'(mem_we), 32'(st));
                    if (st) chk("mem_wdata", 32'(mem_wdata), 32'(p_d_wdata));
                    e.own_d = gd;
                    e.st    = st;
                    e.data  = shadow[a[5:0]];
                    e.due   = cyc + (st ? 1 : LAT);
                    if (st) shadow[a[5:0]] = p_d_wdata;
                    q.push_back(e);
                    last_d = gd;
                end else begin
                    chk("mem_we_idle", 32'(mem_we), 32'd0);
                end
                busy_exp = (q.size() != 0);
                chk("busy", 32'(busy), 32'(busy_exp));
                rv_i = 1'b0;
                rv_d = 1'b0;
                if (q.size() != 0 && q[0].due == cyc) begin
                    e    = q.pop_front();
                    rv_d = e.own_d;
                    rv_i = !e.own_d;
                    if (!e.st) begin
                        if (e.own_d) exp_d_rdata = e.data;
                        else exp_if_rdata = e.data;
                    end
                end
                chk("if_rvalid", 32'(if_rvalid), 32'(rv_i));
                chk("d_rvalid", 32'(d_rvalid), 32'(rv_d));
                chk("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
                chk("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
                prev_idle = !busy_exp;
            end
            prev_reset = reset;
            p_if_req   = if_req;
            p_if_addr  = if_addr;
            p_d_req    = d_req;
            p_d_we     = d_we;
            p_d_addr   = d_addr;
            p_d_wdata  = d_wdata;
        end
    end

    // Stimulus
    bit g_if, g_d;

    task automatic step();
        @(negedge clk);
        g_if = if_gnt;
        g_d  = d_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (n) step();
    endtask

    task automatic if_access(input logic [15:0] addr);
        int n = 0;
        if_req  = 1'b1;
        if_addr = addr;
        do begin step(); n++; end while (!g_if && n < 20);
        if (!g_if) timeout_fail("if_access");
        if_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        int n = 0;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wd;
        do begin step(); n++; end while (!g_d && n < 20);
        if (!g_d) timeout_fail("d_access");
        d_req = 1'b0;
    endtask

    initial begin : stimulus
        int dg, ig, n;
        repeat (3) step();
        reset = 1'b0;

        if_access(16'h0004);
        idle_wait(6);
        d_access(1'b1, 16'h0010, 16'h1234);
        idle_wait(1);
        d_access(1'b0, 16'h0010, 16'h0000);
        idle_wait(6);

        // Continuous contention
        dg = 0;
        ig = 0;
        if_req  = 1'b1;
        if_addr = 16'h0003;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0021;
        for (int c = 0; c < 40; c++) begin
            step();
            if (g_d) dg++;
            if (g_if) ig++;
        end
        idle_wait(6);
`ifdef MEM_ARB_RR_EN
        chk("rr_balance", 32'((dg - ig) * (dg - ig) <= 1), 32'd1);
`else
        chk("fixed_if_starved", 32'(ig), 32'd0);
`endif
        chk("contention_grants", 32'(dg >= 5), 32'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (if_req && !g_if) begin
                if ($urandom_range(0, 19) == 0) if_req = 1'b0;
            end else begin
                if_req  = ($urandom_range(0, 2) == 0);
                if_addr = 16'($urandom_range(0, 63));
            end
            if (d_req && !g_d) begin
                if ($urandom_range(0, 19) == 0) d_req = 1'b0;
            end else begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 63));
                d_wdata = 16'($urandom);
            end
            step();
        end
        idle_wait(8);

        // Reset while a load is in WAIT
        n = 0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0007;
        do begin step(); n++; end while (!g_d && n < 20);
        if (!g_d) timeout_fail("reset_load");
        d_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        if_access(16'h0009);
        idle_wait(8);

        chk("drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 16-bit memory between two requesters: the instruction-fetch path (IF) and the load/store path (D).
- Sits between the multicycle core's fetch/MEM logic and a unified RAM that replaces the separate instruction and data memories.
- Uses a request/grant/response handshake, a configurable read latency, and runs one access at a time.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  one-cycle grant to the fetch requester.
- if_rvalid  out  1  one-cycle fetch data valid.
- if_rdata  out  DW  fetch data; held until the next fetch response.
- d_req  in  1  load/store request; held with d_we, d_addr and d_wdata stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle grant to the data requester.
- d_rvalid  out  1  one-cycle load data valid or store acknowledge.
- d_rdata  out  DW  load data; held until the next load response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: every output is 0, the FSM is in IDLE, the wait counter is 0, and the round-robin pointer points to D.
- FSM states:
  - IDLE: samples requests. If any request is high, it picks a winner, latches owner, we, addr and wdata, and moves to ISSUE.
  - ISSUE: lasts exactly one cycle. It drives the owner's gnt=1, mem_en=1, mem_addr and mem_wdata, and mem_we = we. A store goes to RESP; a load goes to WAIT.
  - WAIT: counts LAT-1 cycles (0 cycles when LAT=1), then goes to RESP.
  - RESP: for a load, captures mem_rdata into the owner's rdata. In both cases it pulses the owner's rvalid, then returns to IDLE.
- Timing, with a request first sampled in IDLE at cycle k:
  - gnt and mem_en are high in cycle k+1.
  - Load: rvalid is high in cycle k+1+LAT.
  - Store: rvalid is high in cycle k+2.
  - The FSM is in IDLE in the cycle after rvalid; the earliest next grant is rvalid+2.
- Arbitration (default): fixed priority, with D beating IF on simultaneous requests.
- The IF requester never writes, so mem_we is always 0 for an IF-owned access.
- Requests arriving while busy are ignored until IDLE. A request dropped before IDLE samples it is never granted.
- Requester inputs may change after gnt; the arbiter uses only its latched copies.
- Outputs outside ISSUE: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- Reset mid-operation (any state): the transaction is discarded, no rvalid is produced, the next cycle is IDLE, and the memory is not written unless mem_we was already high in the reset cycle.
- Address arithmetic: none. Addresses pass through unchanged, with no wrap logic.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests, the requester not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, D over IF. IF may starve while d_req is held continuously.

Decomposition:
- Package mem_arb_pkg holds:
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP).
  - Owner encoding (OWN_IF, OWN_D).
  - LAT_MIN=1 and LAT_MAX=4 with an elaboration-time range check.
  - Wait-counter width constant (3 bits).
- Sub-module arb_pick: a combinational winner selection taking if_req, d_req and the last owner, with the RR/fixed choice under the macro.

Test Plan (LAT=2):
- Fetch read: memory word 0x0004=0xA5A5, if_req with if_addr=0x0004 at cycle 0 -> cycle 1 if_gnt=1, mem_en=1, mem_addr=0x0004, mem_we=0; cycle 3 if_rvalid=1, if_rdata=0xA5A5; busy low from cycle 4.
- Store then load: d_we=1, d_addr=0x0010, d_wdata=0x1234 at cycle 0 -> cycle 1 mem_we=1; cycle 2 d_rvalid=1. A load from 0x0010 at cycle 3 -> cycle 4 d_gnt=1; cycle 6 d_rvalid=1, d_rdata=0x1234.
- Contention: if_req and d_req (load) both high at cycle 0 -> d_gnt at cycle 1, d_rvalid at cycle 3, if_gnt at cycle 5, if_rvalid at cycle 7, with no overlapping mem_en.
- Continuous contention for 20 cycles:
  - Without MEM_ARB_RR_EN, every grant goes to D.
  - With MEM_ARB_RR_EN, grants strictly alternate D, IF, D, IF.
- Reset during WAIT: load granted at cycle 1, reset high at cycle 2 -> no d_rvalid at cycle 3; all outputs 0 and busy=0 at cycle 3; a fetch at cycle 4 completes normally at cycle 7.
- Withdrawn request: IF busy, d_req high at cycles 1-2 then low at cycle 3 onward -> d_gnt is never asserted and the FSM stays in IDLE after the fetch completes.
